// File: rtl/snooper_pkg.sv
// Shared definitions for multi_channel_snooper.
// - FSM state encodings (IDLE, MEASURE, REPORT)
// - Report layout: report_words() and per-channel word offsets
// - sat_add(): addition that clips at all-ones of a given width
package snooper_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] REPORT  = 2'd2;

  // Per-channel word offsets inside the report, after the leading cycle count.
  localparam int unsigned FLITS        = 0;
  localparam int unsigned PKTS         = 1;
  localparam int unsigned BYTES        = 2;
  localparam int unsigned MAX          = 3;
  localparam int unsigned WORDS_PER_CH = 4;

  function automatic int unsigned report_words(input int unsigned num_ch);
    return 1 + WORDS_PER_CH * num_ch;
  endfunction

  // Returns a + b, clipped to 2**width - 1 (width in 1..64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/multi_channel_snooper_if.sv
// 64-bit AXI-Stream report link of multi_channel_snooper.
// - report_TDATA  : result word
// - report_TKEEP  : byte keep (always all ones)
// - report_TVALID : word valid
// - report_TREADY : consumer ready
// - report_TLAST  : final word of the report
// master = snooper (producer), slave = consumer.
interface multi_channel_snooper_if;
  logic [63:0] report_TDATA;
  logic [7:0]  report_TKEEP;
  logic        report_TVALID;
  logic        report_TREADY;
  logic        report_TLAST;

  modport master (
    output report_TDATA, report_TKEEP, report_TVALID, report_TLAST,
    input  report_TREADY
  );

  modport slave (
    input  report_TDATA, report_TKEEP, report_TVALID, report_TLAST,
    output report_TREADY
  );
endinterface

// File: rtl/keep_popcount.sv
// Combinational population count of a TKEEP vector.
// - i_keep  : keep bits
// - o_count : number of set bits, $clog2(TKEEP_WIDTH)+1 wide
module keep_popcount #(
  parameter int unsigned TKEEP_WIDTH = 64
) (
  input  logic [TKEEP_WIDTH-1:0]         i_keep,
  output logic [$clog2(TKEEP_WIDTH):0]   o_count
);
  localparam int unsigned CNT_W = $clog2(TKEEP_WIDTH) + 1;

  always_comb begin
    o_count = '0;
    for (int i = 0; i < TKEEP_WIDTH; i++) begin
      o_count = o_count + CNT_W'(i_keep[i]);
    end
  end
endmodule

// File: rtl/multi_channel_snooper.sv
// Passive per-channel traffic monitor with windowed statistics and an AXI-Stream report.
// - clk, areset          : clock, synchronous active-high reset
// - mon_TKEEP/TVALID/TREADY/TLAST : tapped links, channel c at slice c
// - measure              : level; high opens the window, low closes it
// - report               : 64-bit report stream (master modport)
// - packet_size(_valid)  : per-channel size strobe of each completed packet
// - busy                 : high while measuring or reporting
module multi_channel_snooper
  import snooper_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 512,
  parameter int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned COUNT_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [NUM_CH*TKEEP_WIDTH-1:0] mon_TKEEP,
  input  logic [NUM_CH-1:0]             mon_TVALID,
  input  logic [NUM_CH-1:0]             mon_TREADY,
  input  logic [NUM_CH-1:0]             mon_TLAST,
  input  logic                          measure,
  multi_channel_snooper_if.master       report,
  output logic [NUM_CH*64-1:0]          packet_size,
  output logic [NUM_CH-1:0]             packet_size_valid,
  output logic                          busy
);
  localparam int unsigned PCW = $clog2(TKEEP_WIDTH) + 1;
  localparam int unsigned RW  = report_words(NUM_CH);
  localparam int unsigned IW  = $clog2(RW);

  logic [1:0]             r_state;
  logic [IW-1:0]          r_idx;
  logic [COUNT_WIDTH-1:0] r_cycles;
  logic [COUNT_WIDTH-1:0] r_flits [NUM_CH];
  logic [COUNT_WIDTH-1:0] r_pkts  [NUM_CH];
  logic [COUNT_WIDTH-1:0] r_bytes [NUM_CH];
  logic [COUNT_WIDTH-1:0] r_max   [NUM_CH];
  logic [63:0]            r_acc   [NUM_CH];
  logic [63:0]            r_psize [NUM_CH];
  logic [NUM_CH-1:0]      r_psize_vld;

  logic [PCW-1:0]         w_pop       [NUM_CH];
  logic [63:0]            w_size      [NUM_CH];
  logic [COUNT_WIDTH-1:0] w_size_clip [NUM_CH];
  logic [NUM_CH-1:0]      w_beat;
  logic [63:0]            w_word;
  logic                   w_last;
  logic                   w_hs;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    keep_popcount #(
      .TKEEP_WIDTH (TKEEP_WIDTH)
    ) u_pop (
      .i_keep  (mon_TKEEP[c*TKEEP_WIDTH +: TKEEP_WIDTH]),
      .o_count (w_pop[c])
    );
    assign packet_size[c*64 +: 64] = r_psize[c];
  end

  assign w_beat = mon_TVALID & mon_TREADY;

  // Size of the packet including the current beat; the clipped copy feeds the max tracker.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_size[c]      = sat_add(r_acc[c], 64'(w_pop[c]), 64);
      w_size_clip[c] = COUNT_WIDTH'(sat_add(w_size[c], 64'd0, COUNT_WIDTH));
    end
  end

  always_comb begin
    w_word = 64'(r_cycles);
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_idx == IW'(1 + WORDS_PER_CH * c + FLITS)) w_word = 64'(r_flits[c]);
      if (r_idx == IW'(1 + WORDS_PER_CH * c + PKTS))  w_word = 64'(r_pkts[c]);
      if (r_idx == IW'(1 + WORDS_PER_CH * c + BYTES)) w_word = 64'(r_bytes[c]);
      if (r_idx == IW'(1 + WORDS_PER_CH * c + MAX))   w_word = 64'(r_max[c]);
    end
  end

  assign w_last               = (r_idx == IW'(RW - 1));
  assign w_hs                 = (r_state == REPORT) && report.report_TREADY;
  assign report.report_TVALID = (r_state == REPORT);
  assign report.report_TDATA  = (r_state == REPORT) ? w_word : 64'd0;
  assign report.report_TLAST  = (r_state == REPORT) && w_last;
  assign report.report_TKEEP  = 8'hFF;
  assign packet_size_valid    = r_psize_vld;
  assign busy                 = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_cycles <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_idx    <= '0;
          r_cycles <= '0;
          if (measure) r_state <= MEASURE;
        end
        MEASURE: begin
          r_cycles <= COUNT_WIDTH'(sat_add(64'(r_cycles), 64'd1, COUNT_WIDTH));
          if (!measure) r_state <= REPORT;
        end
        REPORT: begin
          if (w_hs) begin
            if (w_last) begin
              r_idx   <= '0;
              r_state <= IDLE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Counters are frozen during REPORT so the report words stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_psize_vld <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_flits[c] <= '0;
        r_pkts[c]  <= '0;
        r_bytes[c] <= '0;
        r_max[c]   <= '0;
        r_acc[c]   <= '0;
        r_psize[c] <= '0;
      end
    end else begin
      r_psize_vld <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_state == IDLE) begin
          r_flits[c] <= '0;
          r_pkts[c]  <= '0;
          r_bytes[c] <= '0;
          r_max[c]   <= '0;
          r_acc[c]   <= '0;
        end else if ((r_state == MEASURE) && w_beat[c]) begin
          r_flits[c] <= COUNT_WIDTH'(sat_add(64'(r_flits[c]), 64'd1, COUNT_WIDTH));
          r_bytes[c] <= COUNT_WIDTH'(sat_add(64'(r_bytes[c]), 64'(w_pop[c]), COUNT_WIDTH));
          if (mon_TLAST[c]) begin
            r_pkts[c]      <= COUNT_WIDTH'(sat_add(64'(r_pkts[c]), 64'd1, COUNT_WIDTH));
            r_max[c]       <= (w_size_clip[c] > r_max[c]) ? w_size_clip[c] : r_max[c];
            r_acc[c]       <= '0;
            r_psize[c]     <= w_size[c];
            r_psize_vld[c] <= 1'b1;
          end else begin
            r_acc[c] <= w_size[c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_snooper.sv
// Self-checking bench for multi_channel_snooper (NUM_CH=2, TDATA_WIDTH=64, COUNT_WIDTH=8).
// A window/report model built from integer counters and a word queue is compared every
// cycle; literal report contents pin the model for each directed scenario.
module tb_multi_channel_snooper;
  localparam int unsigned NCH = 2;
  localparam int unsigned KW  = 8;
  localparam int unsigned NW  = 1 + 4 * NCH;
  localparam longint      SAT = 255;

  logic              clk = 1'b0;
  logic              areset = 1'b1;
  logic              measure = 1'b0;
  logic [NCH*KW-1:0] keep = '0;
  logic [NCH-1:0]    tv = '0;
  logic [NCH-1:0]    tr = '0;
  logic [NCH-1:0]    tl = '0;
  logic [NCH*64-1:0] psize;
  logic [NCH-1:0]    pvld;
  logic              busy;

  multi_channel_snooper_if u_if ();

  multi_channel_snooper #(
    .TDATA_WIDTH (64),
    .TKEEP_WIDTH (KW),
    .NUM_CH      (NCH),
    .COUNT_WIDTH (8)
  ) u_dut (
    .clk               (clk),
    .areset            (areset),
    .mon_TKEEP         (keep),
    .mon_TVALID        (tv),
    .mon_TREADY        (tr),
    .mon_TLAST         (tl),
    .measure           (measure),
    .report            (u_if),
    .packet_size       (psize),
    .packet_size_valid (pvld),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model: 0 = idle, 1 = window open, 2 = reporting.
  int     m_phase = 0;
  longint m_cycles;
  longint m_flits [NCH];
  longint m_pkts  [NCH];
  longint m_bytes [NCH];
  longint m_max   [NCH];
  longint m_acc   [NCH];
  longint m_psize [NCH];
  bit     m_pvld  [NCH];
  longint m_rep[$];

  longint cap[$];
  bit     cap_last[$];
  longint exp_w [NW];

  function automatic longint clip(input longint v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cycles = 0;
    for (int c = 0; c < NCH; c++) begin
      m_flits[c] = 0; m_pkts[c] = 0; m_bytes[c] = 0; m_max[c] = 0; m_acc[c] = 0;
    end
  endtask

  task automatic model_step();
    longint pop;
    longint sz;
    if (areset) begin
      m_phase = 0;
      model_clear();
      for (int c = 0; c < NCH; c++) begin m_psize[c] = 0; m_pvld[c] = 0; end
      m_rep.delete();
    end else begin
      for (int c = 0; c < NCH; c++) m_pvld[c] = 0;
      case (m_phase)
        0: begin
          model_clear();
          if (measure) m_phase = 1;
        end
        1: begin
          m_cycles++;
          for (int c = 0; c < NCH; c++) begin
            if (tv[c] && tr[c]) begin
              pop = longint'($countones(keep[c*KW +: KW]));
              m_flits[c]++;
              m_bytes[c] += pop;
              m_acc[c]   += pop;
              if (tl[c]) begin
                sz = m_acc[c];
                m_pkts[c]++;
                if (sz > m_max[c]) m_max[c] = sz;
                m_acc[c]   = 0;
                m_psize[c] = sz;
                m_pvld[c]  = 1;
              end
            end
          end
          if (!measure) begin
            m_rep.push_back(clip(m_cycles));
            for (int c = 0; c < NCH; c++) begin
              m_rep.push_back(clip(m_flits[c]));
              m_rep.push_back(clip(m_pkts[c]));
              m_rep.push_back(clip(m_bytes[c]));
              m_rep.push_back(clip(m_max[c]));
            end
            m_phase = 2;
          end
        end
        default: begin
          if (u_if.report_TREADY) begin
            void'(m_rep.pop_front());
            if (m_rep.size() == 0) m_phase = 0;
          end
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_phase != 0));
      check("tvalid", 64'(u_if.report_TVALID), 64'(m_phase == 2));
      check("tkeep", 64'(u_if.report_TKEEP), 64'hFF);
      if (m_phase == 2 && m_rep.size() > 0) begin
        check("tdata", u_if.report_TDATA, m_rep[0]);
        check("tlast", 64'(u_if.report_TLAST), 64'(m_rep.size() == 1));
      end
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("psize_vld%0d", c), 64'(pvld[c]), 64'(m_pvld[c]));
        check($sformatf("psize%0d", c), psize[c*64 +: 64], m_psize[c]);
      end
      if (u_if.report_TVALID && u_if.report_TREADY) begin
        cap.push_back(longint'(u_if.report_TDATA));
        cap_last.push_back(u_if.report_TLAST);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int c, input logic [7:0] k, input logic last);
    tv[c] = 1'b1; tr[c] = 1'b1; tl[c] = last; keep[c*KW +: KW] = k;
    tick();
    tv[c] = 1'b0; tr[c] = 1'b0; tl[c] = 1'b0; keep[c*KW +: KW] = '0;
  endtask

  task automatic open_window();
    measure = 1'b1;
    tick();
  endtask

  task automatic close_window();
    measure = 1'b0;
    tick();
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic drain(input int mode);
    int n = 0;
    while (busy && n < 200) begin
      u_if.report_TREADY = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      tick();
      n++;
    end
    u_if.report_TREADY = 1'b0;
    check("drain_done", 64'(busy), 64'd0);
  endtask

  task automatic check_words(input string name);
    check({name, "_count"}, 64'(cap.size()), 64'(NW));
    if (cap.size() == NW) begin
      for (int i = 0; i < NW; i++) check($sformatf("%s_w%0d", name, i), cap[i], exp_w[i]);
      check({name, "_tlast_final"}, 64'(cap_last[NW-1]), 64'd1);
      check({name, "_tlast_early"}, 64'(cap_last[NW-2]), 64'd0);
    end
  endtask

  initial begin
    u_if.report_TREADY = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    areset = 1'b0;
    check("rst_tvalid", 64'(u_if.report_TVALID), 64'd0);
    check("rst_tdata", u_if.report_TDATA, 64'd0);
    check("rst_tlast", 64'(u_if.report_TLAST), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_psize", psize[63:0], 64'd0);
    tick();

    // Basic window: 10 measure cycles, one 20-byte packet on ch0.
    cap.delete();
    open_window();
    beat(0, 8'hFF, 1'b0);
    beat(0, 8'hFF, 1'b0);
    beat(0, 8'h0F, 1'b1);
    check("basic_psize", psize[63:0], 64'd20);
    check("basic_strobe", 64'(pvld[0]), 64'd1);
    tick();
    check("basic_strobe_off", 64'(pvld[0]), 64'd0);
    repeat (5) tick();
    close_window();
    drain(0);
    exp_w = '{10, 3, 1, 20, 20, 0, 0, 0, 0};
    check_words("basic");

    // Gating on ch1 plus report backpressure.
    cap.delete();
    open_window();
    tv[1] = 1'b1; tr[1] = 1'b0; keep[KW +: KW] = 8'hFF;
    repeat (5) tick();
    beat(1, 8'hFF, 1'b1);
    tick();
    close_window();
    drain(1);
    exp_w = '{8, 0, 0, 0, 0, 1, 1, 8, 8};
    check_words("gate");

    // Saturation: 300 single-beat packets on ch0.
    cap.delete();
    open_window();
    tv[0] = 1'b1; tr[0] = 1'b1; tl[0] = 1'b1; keep[KW-1:0] = 8'hFF;
    repeat (300) tick();
    tv = '0; tr = '0; tl = '0; keep = '0;
    close_window();
    drain(0);
    exp_w = '{255, 255, 255, 255, 8, 0, 0, 0, 0};
    check_words("sat");

    // Boundaries: packet already open at window start, open packet at close,
    // measure re-raised during report.
    cap.delete();
    beat(0, 8'hFF, 1'b0);
    open_window();
    beat(0, 8'h0F, 1'b1);
    check("bound_psize", psize[63:0], 64'd4);
    beat(0, 8'hFF, 1'b0);
    beat(0, 8'hFF, 1'b0);
    close_window();
    measure = 1'b1;
    repeat (3) tick();
    check("bound_busy_hold", 64'(busy), 64'd1);
    measure = 1'b0;
    drain(0);
    exp_w = '{4, 3, 1, 20, 4, 0, 0, 0, 0};
    check_words("bound");
    repeat (3) tick();
    check("bound_stay_idle", 64'(busy), 64'd0);
    open_window();
    check("bound_reopen", 64'(busy), 64'd1);

    // Reset in the middle of a report, then a fresh window.
    beat(1, 8'hFF, 1'b1);
    beat(1, 8'hFF, 1'b1);
    close_window();
    u_if.report_TREADY = 1'b1;
    repeat (3) tick();
    u_if.report_TREADY = 1'b0;
    areset = 1'b1;
    tick();
    check("rst_mid_tvalid", 64'(u_if.report_TVALID), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    areset = 1'b0;
    tick();
    cap.delete();
    open_window();
    beat(1, 8'h0F, 1'b1);
    close_window();
    drain(0);
    exp_w = '{2, 0, 0, 0, 0, 1, 1, 4, 4};
    check_words("fresh");

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
